instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the multi-cycle CPU, i.e. the requesting side of the instruction memory. It holds the fetch pointer, drives the word address into the instruction memory, and absorbs the memory's one-cycle registered read latency. It latches the returned word into the instruction register and presents it to the control unit with a valid/ready handshake. Branch and jump redirects from the control unit squash any in-flight fetch.

## Interface

- RESET_PC, default 32'h0000_0000: fetch address loaded at reset; bits [1:0] must be 00.

- clk  in  1  single system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_req  in  1  control unit requests the next instruction; sampled in IDLE only.
- ir_ready  in  1  control unit consumes the current ir; meaningful only while ir_valid=1.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  new fetch address, sampled when redirect=1.
- im_dout  in  32  instruction memory read data; valid one cycle after im_addr is presented.
- im_addr  out  10  word address to instruction memory, equal to fpc[11:2].
- ir  out  32  instruction register.
- ir_valid  out  1  ir holds a fresh, unconsumed instruction.
- pc  out  32  byte address of the instruction in ir.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_err  out  1  sticky; set by a misaligned redirect.

## Operation

- Internal fetch pointer fpc[31:0]; im_addr = fpc[11:2] at all times.
- States: IDLE, ISSUE, CAPTURE, VALID.
- **IDLE**
  - If fetch_req=1, go to ISSUE.
- **ISSUE**
  - im_addr is stable for one cycle; the memory registers its output at the end of this cycle.
  - Next state is CAPTURE.
- **CAPTURE**
  - On the end-of-cycle edge: ir <= im_dout, pc <= fpc, ir_valid <= 1.
  - Next state is VALID.
- **VALID**
  - ir_valid=1 is held until ir_ready=1.
  - On the accept edge: ir_valid <= 0, fpc <= fpc + 4, go to IDLE.
  - ir and pc keep their values after the accept, because the multi-cycle datapath reads ir in later cycles.
- **Redirect** (takes priority over every other transition):
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - In ISSUE or CAPTURE: the in-flight word is discarded, ir/pc/ir_valid are unchanged, and the next state is ISSUE.
  - In VALID: ir_valid <= 0, next state IDLE. If ir_ready=1 in the same cycle, the instruction counts as consumed, but fpc takes the redirect target, not fpc+4.
  - In IDLE: only fpc is updated. If fetch_req=1 in the same cycle, go to ISSUE using the new fpc.
- **Misalignment**
  - A redirect with redirect_pc[1:0] != 0 sets fetch_err=1.
  - The low bits are forced to 00 and fetching proceeds normally.
  - fetch_err is cleared only by reset.
- **Arithmetic**
  - fpc and pc are full 32-bit values; +4 wraps modulo 2^32.
  - im_addr uses only fpc[11:2], so the 4 KB memory aliases: fpc=0x0000_1000 gives im_addr=0.

## Timing

- **Reset (rst_n=0 at a posedge)**
  - state=IDLE, fpc=RESET_PC, pc=RESET_PC, ir=0, ir_valid=0, fetch_err=0.
  - Derived outputs: im_addr=RESET_PC[11:2], pc_plus4=RESET_PC+4.
  - Reset overrides redirect and fetch_req in the same cycle.
  - Reset mid-fetch abandons the fetch; no ir update occurs.
- **Latency**
  - With fetch_req=1 in IDLE at cycle 0: ISSUE in cycle 1, CAPTURE in cycle 2, ir_valid=1 from cycle 3.
  - That is 3 cycles from request to valid.
- **Throughput**
  - Minimum 4 cycles per instruction (IDLE→ISSUE→CAPTURE→VALID), given fetch_req re-asserted immediately after each accept.
- **Output timing**
  - All outputs are registered, except im_addr and pc_plus4, which are direct functions of registers.

## Configuration

- **FETCH_PERF_EN defined:**
  - Adds output port fetch_count (out, 32 bits).
  - Resets to 0 and increments by 1 on each accept edge (ir_valid & ir_ready), including an accept coincident with a redirect.
  - Squashed fetches are not counted; the counter wraps at 2^32.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Test plan

- **Reset:** hold rst_n=0 for 2 cycles with RESET_PC=0 → ir=0, ir_valid=0, pc=0, pc_plus4=4, im_addr=0, fetch_err=0.
- **Single fetch:** memory word 0 = 32'h014A4822; pulse fetch_req in cycle 0 → ir_valid=1 in cycle 3, ir=32'h014A4822, pc=0.
- **Sequential fetches:** memory words 0..2 = 32'h014A4822, 32'h21290001, 32'h08000001; ir_ready and fetch_req held high → pc sequence 0, 4, 8 with matching ir values, one instruction every 4 cycles.
- **Squash:** redirect=1 with redirect_pc=0x4 while in CAPTURE for address 0x8 → no ir_valid for the 0x8 fetch; the next ir_valid has pc=4, ir=32'h21290001.
- **Redirect and accept:** in VALID with pc=0, assert ir_ready=1 and redirect=1 with redirect_pc=0xA in the same cycle → ir_valid=0, fetch_err=1, next fetch at pc=8 (im_addr=2), fetch_count +1 if FETCH_PERF_EN is defined.
- **Wrap:** redirect to 0xFFC, fetch, accept → next im_addr=0, next pc=0x0000_1000, ir=word 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetch pointer, 1-cycle imem latency, IR handshake.
// Optional FETCH_PERF_EN adds the fetch_count accept counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_dout,
  output logic [9:0]  im_addr,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = ir_valid_q & ir_ready;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    if (redirect) begin
      // Redirect wins; any in-flight word is simply never captured.
      fpc_d = {redirect_pc[31:2], 2'b00};
      err_d = err_q | (|redirect_pc[1:0]);
      unique case (state_q)
        IDLE:    state_d = fetch_req ? ISSUE : IDLE;
        ISSUE,
        CAPTURE: state_d = ISSUE;
        VALID: begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE:  if (fetch_req) state_d = ISSUE;
        ISSUE: state_d = CAPTURE;
        CAPTURE: begin
          ir_d       = im_dout;
          pc_d       = fpc_q;
          ir_valid_d = 1'b1;
          state_d    = VALID;
        end
        VALID: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            fpc_d      = fpc_q + 32'd4;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d       = accept ? cnt_q + 32'd1 : cnt_q;
  assign fetch_count = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 32'h0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign im_addr   = fpc_q[11:2];
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed plan items then random ops.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_dout;
  logic [9:0]  im_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_dout     (im_dout),
    .im_addr     (im_addr),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) im_dout <= mem[im_addr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_fpc;
  logic        m_err;
  logic [31:0] m_cnt;
  logic [31:0] last_pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Monitor: each fresh valid must match the oldest expected fetch.
  initial begin
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (ir_valid === 1'b1 && !prev_v) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid_pc", pc, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("mon_ir", ir, e.ir);
          chk("mon_pc", pc, e.pc);
          chk("mon_pc_plus4", pc_plus4, e.pc + 32'd4);
          chk("mon_im_addr", 32'(im_addr), 32'(e.pc[11:2]));
          chk("mon_fetch_err", 32'(fetch_err), 32'(e.err));
        end
      end
      prev_v = (ir_valid === 1'b1);
    end
  end

  task automatic push_exp();
    exp_t e;
    e.pc  = m_fpc;
    e.ir  = mem[m_fpc[11:2]];
    e.err = m_err;
    expq.push_back(e);
    last_pc = m_fpc;
  endtask

  task automatic apply_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    m_fpc       = {tgt[31:2], 2'b00};
    m_err       = m_err | (|tgt[1:0]);
  endtask

  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      fetch_req = 1'b0;
      redirect  = 1'b0;
    end while (ir_valid !== 1'b1 && n < 20);
    chk("latency", n, exp_lat);
  endtask

  task automatic accept(input int hold, input bit redir,
                        input logic [31:0] tgt);
    repeat (hold) begin
      @(negedge clk);
      chk("valid_hold", 32'(ir_valid), 32'd1);
    end
    ir_ready = 1'b1;
    m_cnt    = m_cnt + 32'd1;
    if (redir) apply_redirect(tgt);
    else m_fpc = m_fpc + 32'd4;
    @(negedge clk);
    ir_ready = 1'b0;
    redirect = 1'b0;
    chk("acc_valid_low", 32'(ir_valid), 32'd0);
    chk("acc_pc_kept", pc, last_pc);
    chk("acc_im_addr", 32'(im_addr), 32'(m_fpc[11:2]));
    chk("acc_fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef FETCH_PERF_EN
    chk("acc_fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic fetch_one(input int hold, input bit redir,
                           input logic [31:0] tgt);
    push_exp();
    fetch_req = 1'b1;
    wait_valid(3);
    accept(hold, redir, tgt);
  endtask

  task automatic idle_redirect(input logic [31:0] tgt, input bit req);
    apply_redirect(tgt);
    fetch_req = req;
    if (req) begin
      push_exp();
      wait_valid(3);
      accept(0, 1'b0, 32'h0);
    end else begin
      @(negedge clk);
      redirect = 1'b0;
      chk("idle_redir_im_addr", 32'(im_addr), 32'(m_fpc[11:2]));
      chk("idle_redir_valid", 32'(ir_valid), 32'd0);
    end
  endtask

  task automatic squash_fetch(input int when, input logic [31:0] tgt,
                              input int hold);
    logic [31:0] s_ir;
    logic [31:0] s_pc;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    if (when == 2) @(negedge clk);
    s_ir = ir;
    s_pc = pc;
    apply_redirect(tgt);
    @(negedge clk);
    redirect = 1'b0;
    chk("squash_ir_kept", ir, s_ir);
    chk("squash_pc_kept", pc, s_pc);
    chk("squash_valid_low", 32'(ir_valid), 32'd0);
    push_exp();
    wait_valid(2);
    accept(hold, 1'b0, 32'h0);
  endtask

  task automatic reset_mid_fetch(input int k);
    fetch_req = 1'b1;
    repeat (k) begin
      @(negedge clk);
      fetch_req = 1'b0;
    end
    rst_n = 1'b0;
    m_fpc = 32'h0;
    m_err = 1'b0;
    m_cnt = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_valid", 32'(ir_valid), 32'd0);
    chk("rst_mid_ir", ir, 32'h0);
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_err", 32'(fetch_err), 32'd0);
    chk("rst_mid_im_addr", 32'(im_addr), 32'd0);
  endtask

  initial begin
    int hits;
    int n;
    int op;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h014A4822;
    mem[1] = 32'h21290001;
    mem[2] = 32'h08000001;
    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    m_fpc       = 32'h0;
    m_err       = 1'b0;
    m_cnt       = 32'h0;
    last_pc     = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_count", fetch_count, 32'h0);
`endif
    rst_n = 1'b1;

    // Back-to-back fetches with request and ready held high.
    for (int i = 0; i < 3; i++) begin
      push_exp();
      m_fpc = m_fpc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    fetch_req = 1'b1;
    ir_ready  = 1'b1;
    hits = 0;
    n    = 0;
    while (hits < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (ir_valid === 1'b1) begin
        hits++;
        chk("throughput_cycle", n, 4 * hits - 1);
      end
    end
    fetch_req = 1'b0;
    @(negedge clk);
    ir_ready = 1'b0;
    chk("throughput_hits", hits, 3);
    last_pc = 32'h8;

    idle_redirect(32'h8, 1'b0);
    squash_fetch(2, 32'h4, 1);

    idle_redirect(32'h0, 1'b0);
    fetch_one(0, 1'b1, 32'hA);
    chk("misalign_err", 32'(fetch_err), 32'd1);
    fetch_one(2, 1'b0, 32'h0);

    idle_redirect(32'hFFC, 1'b1);
    fetch_one(0, 1'b0, 32'h0);
    idle_redirect(32'hFFFF_FFFC, 1'b1);
    chk("wrap32_im_addr", 32'(im_addr), 32'd0);

    reset_mid_fetch(2);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4)
        fetch_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                  $urandom);
      else if (op < 7)
        squash_fetch($urandom_range(1, 2), $urandom, $urandom_range(0, 2));
      else if (op < 9)
        idle_redirect($urandom, 1'($urandom_range(0, 1)));
      else
        reset_mid_fetch($urandom_range(1, 2));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    chk("final_fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef FETCH_PERF_EN
    chk("final_fetch_count", fetch_count, m_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
